// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and small op-decode helpers.
package ex_muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    function automatic logic op_is_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    // rs1 is treated as two's complement for these ops
    function automatic logic op_rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Radix-2 iterative core working on operand magnitudes: shift-add multiply
// or restoring divide, one bit per step, exposing the post-step values.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            start,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] next_hi,
    output logic [XLEN-1:0] next_lo,
    output logic            last
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;
    logic            div_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN:0]   addend;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Multiply keeps {hi,lo} = {partial product, remaining multiplier bits};
    // divide keeps {hi,lo} = {partial remainder, dividend/quotient bits}.
    always_comb begin
        addend  = lo_q[0] ? {1'b0, b_q} : '0;
        sum     = {1'b0, hi_q} + addend;
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        next_hi = '0;
        next_lo = '0;
        if (div_q) begin
            if (!diff[XLEN]) begin
                next_hi = diff[XLEN-1:0];
                next_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                next_hi = shifted[XLEN-1:0];
                next_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[XLEN:1];
            next_lo = {sum[0], lo_q[XLEN-1:1]};
        end
        last = (cnt_q == CW'(XLEN - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= a_mag;
            b_q   <= b_mag;
            div_q <= is_div;
            cnt_q <= '0;
        end else if (step) begin
            hi_q  <= next_hi;
            lo_q  <= next_lo;
            cnt_q <= last ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute-stage multiply/divide unit: handshake FSM, special-case
// shortcuts (divide by zero, signed overflow) and final sign correction.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   reg1_i,
    input  logic [XLEN-1:0]   reg2_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [XLEN-1:0]   wdata_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              stall_req
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_q;
    state_t state_d;

    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic [2:0]      op_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic            wreg_q;

    logic            iter_start;
    logic            iter_step;
    logic [XLEN-1:0] iter_hi;
    logic [XLEN-1:0] iter_lo;
    logic            iter_last;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;

    // Flush takes priority over a new request offered in the same cycle.
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready && !flush;
    assign stall_req = (state_q != ST_IDLE) || accept;

    always_comb begin
        a_neg    = op_rs1_signed(funct3) && reg1_i[XLEN-1];
        b_neg    = op_rs2_signed(funct3) && reg2_i[XLEN-1];
        a_mag    = a_neg ? -reg1_i : reg1_i;
        b_mag    = b_neg ? -reg2_i : reg2_i;
        div_zero = op_is_div(funct3) && (reg2_i == '0);
        div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                   (reg1_i == MOST_NEG) && (reg2_i == '1);
        special  = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = op_is_rem(funct3) ? reg1_i : '1;
        end else if (div_ovf) begin
            special_res = op_is_rem(funct3) ? '0 : reg1_i;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .start   (iter_start),
        .step    (iter_step),
        .is_div  (op_is_div(funct3)),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .next_hi (iter_hi),
        .next_lo (iter_lo),
        .last    (iter_last)
    );

    // Result is built from the values the final iteration is about to
    // commit, so it lands in wdata_o on the same edge CALC ends.
    always_comb begin
        prod = {iter_hi, iter_lo};
        if (a_neg_q ^ b_neg_q) begin
            prod = -prod;
        end
        quot = (a_neg_q ^ b_neg_q) ? -iter_lo : iter_lo;
        rem  = a_neg_q ? -iter_hi : iter_hi;
        final_res = '0;
        if (op_is_div(op_q)) begin
            final_res = op_is_rem(op_q) ? rem : quot;
        end else if (op_q == F3_MUL) begin
            final_res = prod[XLEN-1:0];
        end else begin
            final_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iter_start = 1'b0;
        iter_step  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d    = special ? ST_DONE : ST_CALC;
                        iter_start = !special;
                    end
                end
                ST_CALC: begin
                    iter_step = 1'b1;
                    if (iter_last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            wdata_o   <= '0;
            wd_o      <= '0;
            wreg_o    <= 1'b0;
            op_q      <= F3_MUL;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            wreg_q    <= 1'b0;
        end else if (flush) begin
            res_valid <= 1'b0;
            wreg_o    <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                op_q    <= funct3;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
                wd_o    <= wd_i;
                wreg_q  <= wreg_i;
                if (special) begin
                    wdata_o   <= special_res;
                    res_valid <= 1'b1;
                    wreg_o    <= wreg_i;
                end
            end
        end else if (state_q == ST_CALC) begin
            if (iter_last) begin
                wdata_o   <= final_res;
                res_valid <= 1'b1;
                wreg_o    <= wreg_q;
            end
        end else if (state_q == ST_DONE) begin
            if (res_ready) begin
                res_valid <= 1'b0;
                wreg_o    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, hand-written
// stall/flush/reset sequences and random ops against an arithmetic model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    localparam int LAT_LIMIT = 60;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    ex_muldiv #(
        .XLEN   (32),
        .REG_AW (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .reg1_i    (reg1_i),
        .reg2_i    (reg2_i),
        .wd_i      (wd_i),
        .wreg_i    (wreg_i),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .wdata_o   (wdata_o),
        .wd_o      (wd_o),
        .wreg_o    (wreg_o),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub;
        logic signed [63:0] p;
        logic [63:0]        up;
        logic signed [31:0] a32;
        logic signed [31:0] b32;
        logic signed [31:0] r32;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'h0, b};
        a32 = a;
        b32 = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                r32 = a32 / b32;
                return r32;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                r32 = a32 % b32;
                return r32;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic is_div;
        logic is_signed_div;
        is_div        = (f3 == 3'b100) || (f3 == 3'b101) || (f3 == 3'b110) || (f3 == 3'b111);
        is_signed_div = (f3 == 3'b100) || (f3 == 3'b110);
        if (is_div && b == 0) return 1;
        if (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wd, input logic wr);
        @(negedge clk);
        funct3    = f3;
        reg1_i    = a;
        reg2_i    = b;
        wd_i      = wd;
        wreg_i    = wr;
        req_valid = 1'b1;
        #1;
        checkOutput("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        checkOutput("stall_on_accept", {31'b0, stall_req}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts the cycle after the accept edge as cycle 1.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!res_valid && lat < LAT_LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput("res_valid_after_take", {31'b0, res_valid}, 32'd0);
        checkOutput("wreg_o_after_take", {31'b0, wreg_o}, 32'd0);
        checkOutput("req_ready_after_take", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic runVector(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [4:0] wd;
        logic       wr;
        int         lat;
        wd = 5'($urandom_range(0, 31));
        wr = 1'($urandom_range(0, 1));
        applyStimulus(f3, a, b, wd, wr);
        waitResult(lat);
        checkOutput({name, "_data"}, wdata_o, exp);
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, "_wd"}, {27'b0, wd_o}, {27'b0, wd});
        checkOutput({name, "_wreg"}, {31'b0, wreg_o}, {31'b0, wr});
        releaseResult();
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{"mul_7_m3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{"mulhu_ones",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{"mulh_ones",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{"mulhsu_m1_2",   3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 33};
        vecs[4]  = '{"div_by_zero",   3'b100, 32'd20,         32'd0,          32'hFFFF_FFFF, 1};
        vecs[5]  = '{"rem_by_zero",   3'b110, 32'd20,         32'd0,          32'h0000_0014, 1};
        vecs[6]  = '{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[8]  = '{"rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33};
        vecs[9]  = '{"divu_100_7",    3'b101, 32'd100,        32'd7,          32'd14,        33};
        vecs[10] = '{"remu_100_7",    3'b111, 32'd100,        32'd7,          32'd2,         33};
        vecs[11] = '{"divu_by_zero",  3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        vecs[12] = '{"remu_by_zero",  3'b111, 32'd5,          32'd0,          32'd5,         1};
        vecs[13] = '{"div_m20_3",     3'b100, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA, 33};
        vecs[14] = '{"rem_m20_3",     3'b110, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFE, 33};
        vecs[15] = '{"div_20_m3",     3'b100, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 33};
        vecs[16] = '{"rem_20_m3",     3'b110, 32'd20,         32'hFFFF_FFFD, 32'd2,         33};
        vecs[17] = '{"mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[18] = '{"divu_min_ones", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};

        // Reset state
        #2;
        checkOutput("rst_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("rst_wdata_o", wdata_o, 32'd0);
        checkOutput("rst_wd_o", {27'b0, wd_o}, 32'd0);
        checkOutput("rst_wreg_o", {31'b0, wreg_o}, 32'd0);
        checkOutput("rst_stall_req", {31'b0, stall_req}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            runVector(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Consumer holds off for 5 cycles in DONE
        applyStimulus(3'b000, 32'd3, 32'd5, 5'd9, 1'b1);
        checkOutput("calc_stall_req", {31'b0, stall_req}, 32'd1);
        waitResult(lat);
        checkOutput("hold_latency", 32'(lat), 32'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_wdata", wdata_o, 32'd15);
            checkOutput("hold_res_valid", {31'b0, res_valid}, 32'd1);
            checkOutput("hold_req_ready", {31'b0, req_ready}, 32'd0);
            checkOutput("hold_stall_req", {31'b0, stall_req}, 32'd1);
            checkOutput("hold_wd_o", {27'b0, wd_o}, 32'd9);
        end
        releaseResult();

        // Flush during CALC cycle 10
        applyStimulus(3'b101, 32'd1000, 32'd7, 5'd3, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_calc_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("flush_calc_stall_req", {31'b0, stall_req}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid) seen = 1'b1;
        end
        checkOutput("flush_calc_no_result", {31'b0, seen}, 32'd0);

        // Flush together with a new request: the request must be ignored
        @(negedge clk);
        funct3    = 3'b000;
        reg1_i    = 32'd2;
        reg2_i    = 32'd2;
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        checkOutput("flush_req_no_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        checkOutput("flush_req_stays_idle", {31'b0, stall_req}, 32'd0);
        seen = 1'b0;
        repeat (36) begin
            @(posedge clk);
            #1;
            if (res_valid) seen = 1'b1;
        end
        checkOutput("flush_req_no_result", {31'b0, seen}, 32'd0);

        // Flush while the result is waiting in DONE
        applyStimulus(3'b100, 32'd20, 32'd0, 5'd4, 1'b1);
        waitResult(lat);
        checkOutput("flush_done_latency", 32'(lat), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_done_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("flush_done_wreg_o", {31'b0, wreg_o}, 32'd0);
        checkOutput("flush_done_req_ready", {31'b0, req_ready}, 32'd1);

        // Asynchronous reset in the middle of CALC
        applyStimulus(3'b000, 32'h1234, 32'h5678, 5'd7, 1'b1);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("arst_wdata_o", wdata_o, 32'd0);
        checkOutput("arst_wd_o", {27'b0, wd_o}, 32'd0);
        checkOutput("arst_wreg_o", {31'b0, wreg_o}, 32'd0);
        checkOutput("arst_stall_req", {31'b0, stall_req}, 32'd0);
        checkOutput("arst_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        runVector("divu_9_3_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 33);

        // Random operations against the model
        for (int n = 0; n < 30; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            runVector($sformatf("rand%0d_f3_%0d", n, f3), f3, a, b,
                      refModel(f3, a, b), refLatency(f3, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
